serial_logic32: RTL

- Multi-cycle, bit-serial bitwise logic unit: the sequential counterpart of the parallel 32-bit gate arrays in the ALU datapath.
- Computes AND/OR/XOR/NOR of two operands a group of bits per cycle, using a start/busy/done handshake.
- Used by the multi-cycle datapath control unit when area matters more than latency.
- Result is presented in a holding register with a zero flag.

---
 rtl/serial_logic32_if.sv | 22 ++
 rtl/serial_logic32.sv | 77 +++++++
 2 files changed

// File: rtl/serial_logic32_if.sv
// serial_logic32_if: start/busy/done request bus for the bit-serial logic unit.
// SERIAL_LOGIC_ABORT_EN adds the abort request line.
interface serial_logic32_if #(parameter int WIDTH = 32);
  logic             start;
`ifdef SERIAL_LOGIC_ABORT_EN
  logic             abort;
`endif
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             zero;
`ifdef SERIAL_LOGIC_ABORT_EN
  modport master (output start, abort, op, a, b, input busy, done, result, zero);
  modport slave (input start, abort, op, a, b, output busy, done, result, zero);
`else
  modport master (output start, op, a, b, input busy, done, result, zero);
  modport slave (input start, op, a, b, output busy, done, result, zero);
`endif
endinterface

// File: rtl/serial_logic32.sv
// serial_logic32: bit-serial AND/OR/XOR/NOR unit, BITS_PER_CYCLE bits per RUN cycle.
// SERIAL_LOGIC_ABORT_EN enables abandoning a run via bus.abort.
module serial_logic32 #(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input logic               clk,
  input logic               reset_n,
  serial_logic32_if.slave   bus
);
  localparam int N  = WIDTH / BITS_PER_CYCLE;
  localparam int CW = $clog2(N + 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t                          state, state_next;
  logic [WIDTH-1:0]                sa, sb, sr, sr_next, result_q;
  logic [WIDTH+BITS_PER_CYCLE-1:0] sr_cat;
  logic [BITS_PER_CYCLE-1:0]       grp, ga, gb;
  logic [1:0]                      op_q;
  logic [CW-1:0]                   cnt;
  logic                            zero_q, last, abort_run;
`ifdef SERIAL_LOGIC_ABORT_EN
  assign abort_run = bus.abort;
`else
  assign abort_run = 1'b0;
`endif
  assign ga      = sa[BITS_PER_CYCLE-1:0];
  assign gb      = sb[BITS_PER_CYCLE-1:0];
  assign grp     = op_q == 2'd0 ? ga & gb :
                   op_q == 2'd1 ? ga | gb :
                   op_q == 2'd2 ? ga ^ gb : ~(ga | gb);
  // new group enters at the MSB end, so after N steps bit 0 lands back at bit 0
  assign sr_cat  = {grp, sr};
  assign sr_next = sr_cat[WIDTH+BITS_PER_CYCLE-1:BITS_PER_CYCLE];
  assign last    = cnt == CW'(N - 1);
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    state_next = bus.start ? RUN : IDLE;
      RUN:     state_next = abort_run ? IDLE : last ? DONE : RUN;
      default: state_next = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sa       <= '0;
      sb       <= '0;
      sr       <= '0;
      op_q     <= '0;
      cnt      <= '0;
      result_q <= '0;
      zero_q   <= 1'b1;
    end else if (state == IDLE && bus.start) begin
      sa   <= bus.a;
      sb   <= bus.b;
      op_q <= bus.op;
      sr   <= '0;
      cnt  <= '0;
    end else if (state == RUN) begin
      sa  <= sa >> BITS_PER_CYCLE;
      sb  <= sb >> BITS_PER_CYCLE;
      sr  <= sr_next;
      cnt <= cnt + CW'(1);
      if (last && !abort_run) begin
        result_q <= sr_next;
        zero_q   <= sr_next == '0;
      end
    end
  end
  assign bus.busy   = state != IDLE;
  assign bus.done   = state == DONE;
  assign bus.result = result_q;
  assign bus.zero   = zero_q;
endmodule
